// File: rtl/aurora_pipe_pkg.sv
// aurora_pipe_pkg: shared ID/EX stage state encodings, default widths and payload layout.
package aurora_pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;
    localparam int DEF_DATA_WIDTH        = 16;
    localparam int DEF_REGFILE_LOG2_DEEP = 5;
    localparam int DEF_THREAD_ID_WIDTH   = 2;
    localparam int DEF_BUBBLE_CNT_WIDTH  = 16;
    typedef struct packed {
        logic [3:0]                       ctrl;
        logic [2:0]                       func3;
        logic                             func7;
        logic [DEF_DATA_WIDTH-1:0]        r1;
        logic [DEF_DATA_WIDTH-1:0]        r2;
        logic [DEF_DATA_WIDTH-1:0]        sign_ext;
        logic [DEF_REGFILE_LOG2_DEEP-1:0] wreg1;
        logic [DEF_THREAD_ID_WIDTH-1:0]   thread_id;
    } idex_payload_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with its valid bit; load wins over clear/kill.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic         clear,
    input  logic         kill,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= load | (valid & ~clear & ~kill);
            if (load) q <= d;
        end
    end
endmodule

// File: rtl/idex_pipe_stage.sv
// idex_pipe_stage: flow-controlled ID/EX register with a 1-entry skid buffer,
// per-thread flush and a saturating bubble counter.
module idex_pipe_stage
    import aurora_pipe_pkg::*;
#(
    parameter int PROC_DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PROC_REGFILE_LOG2_DEEP = DEF_REGFILE_LOG2_DEEP,
    parameter int THREAD_ID_WIDTH        = DEF_THREAD_ID_WIDTH,
    parameter int BUBBLE_CNT_WIDTH       = DEF_BUBBLE_CNT_WIDTH,
    localparam int NUM_THREADS           = 2 ** THREAD_ID_WIDTH
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              WRegEn_in,
    input  logic                              WMemEn_in,
    input  logic                              alu_src_in,
    input  logic                              mem_to_reg_in,
    input  logic                              func7_in,
    input  logic [2:0]                        func3_in,
    input  logic [PROC_DATA_WIDTH-1:0]        R1out_in,
    input  logic [PROC_DATA_WIDTH-1:0]        R2out_in,
    input  logic [PROC_DATA_WIDTH-1:0]        sign_ext_in,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_in,
    input  logic [THREAD_ID_WIDTH-1:0]        thread_id_in,
    input  logic [NUM_THREADS-1:0]            flush_thread,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              WRegEn_out,
    output logic                              WMemEn_out,
    output logic                              alu_src_out,
    output logic                              mem_to_reg_out,
    output logic                              func7_out,
    output logic [2:0]                        func3_out,
    output logic [PROC_DATA_WIDTH-1:0]        R1out_out,
    output logic [PROC_DATA_WIDTH-1:0]        R2out_out,
    output logic [PROC_DATA_WIDTH-1:0]        sign_ext_out,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_out,
    output logic [THREAD_ID_WIDTH-1:0]        thread_id_out,
    output logic [BUBBLE_CNT_WIDTH-1:0]       bubble_cnt
);
    typedef struct packed {
        logic                              wreg_en;
        logic                              wmem_en;
        logic                              alu_src;
        logic                              mem_to_reg;
        logic [2:0]                        func3;
        logic                              func7;
        logic [PROC_DATA_WIDTH-1:0]        r1;
        logic [PROC_DATA_WIDTH-1:0]        r2;
        logic [PROC_DATA_WIDTH-1:0]        sign_ext;
        logic [PROC_REGFILE_LOG2_DEEP-1:0] wreg1;
        logic [THREAD_ID_WIDTH-1:0]        tid;
    } payload_t;
    localparam int PW = $bits(payload_t);

    payload_t in_p, main_p, skid_p;
    logic main_valid, skid_valid, kill_main, kill_skid, skid_alive;
    logic acc, xfer, main_stays, main_from_skid;

    assign in_p = {WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in, func3_in, func7_in,
                   R1out_in, R2out_in, sign_ext_in, WReg1_in, thread_id_in};

    assign kill_main  = main_valid & flush_thread[main_p.tid];
    assign kill_skid  = skid_valid & flush_thread[skid_p.tid];
    assign skid_alive = skid_valid & ~kill_skid;
    assign in_ready   = ~skid_valid;
    assign acc        = in_valid & in_ready & ~flush_thread[thread_id_in];
    assign out_valid  = main_valid & ~kill_main;
    assign xfer       = out_valid & out_ready;
    // After kill and pop, the oldest survivor (skid, else the new instr) refills main.
    assign main_stays     = out_valid & ~xfer;
    assign main_from_skid = ~main_stays & skid_alive;

    pipe_slot #(.W(PW)) u_main (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (main_from_skid | (~main_stays & acc)),
        .clear (xfer),
        .kill  (kill_main),
        .d     (main_from_skid ? skid_p : in_p),
        .valid (main_valid),
        .q     (main_p)
    );

    pipe_slot #(.W(PW)) u_skid (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (main_stays & acc),
        .clear (main_from_skid),
        .kill  (kill_skid),
        .d     (in_p),
        .valid (skid_valid),
        .q     (skid_p)
    );

    assign WRegEn_out     = main_p.wreg_en & out_valid;
    assign WMemEn_out     = main_p.wmem_en & out_valid;
    assign alu_src_out    = main_p.alu_src;
    assign mem_to_reg_out = main_p.mem_to_reg;
    assign func3_out      = main_p.func3;
    assign func7_out      = main_p.func7;
    assign R1out_out      = main_p.r1;
    assign R2out_out      = main_p.r2;
    assign sign_ext_out   = main_p.sign_ext;
    assign WReg1_out      = main_p.wreg1;
    assign thread_id_out  = main_p.tid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) bubble_cnt <= '0;
        else if (out_ready && !out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + BUBBLE_CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_idex_pipe_stage.sv
// tb_idex_pipe_stage: table-driven checks of handshake, skid, flush and bubble counting.
module tb_idex_pipe_stage;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in, func7_in;
    logic        WRegEn_out, WMemEn_out, alu_src_out, mem_to_reg_out, func7_out;
    logic [2:0]  func3_in, func3_out;
    logic [15:0] R1out_in, R2out_in, sign_ext_in, R1out_out, R2out_out, sign_ext_out;
    logic [4:0]  WReg1_in, WReg1_out;
    logic [1:0]  thread_id_in, thread_id_out;
    logic [3:0]  flush_thread;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    idex_pipe_stage dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in), .alu_src_in(alu_src_in),
        .mem_to_reg_in(mem_to_reg_in), .func7_in(func7_in), .func3_in(func3_in),
        .R1out_in(R1out_in), .R2out_in(R2out_in), .sign_ext_in(sign_ext_in),
        .WReg1_in(WReg1_in), .thread_id_in(thread_id_in), .flush_thread(flush_thread),
        .out_valid(out_valid), .out_ready(out_ready),
        .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out), .alu_src_out(alu_src_out),
        .mem_to_reg_out(mem_to_reg_out), .func7_out(func7_out), .func3_out(func3_out),
        .R1out_out(R1out_out), .R2out_out(R2out_out), .sign_ext_out(sign_ext_out),
        .WReg1_out(WReg1_out), .thread_id_out(thread_id_out), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [3:0]  fl;
        logic [1:0]  t;
        logic [15:0] d;
        logic        e_ir;
        logic        e_ov;
        logic [1:0]  e_t;
        logic [15:0] e_d;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic iv, input logic ordy, input logic [3:0] fl,
                               input logic [1:0] t, input logic [15:0] d, input logic e_ir,
                               input logic e_ov, input logic [1:0] e_t, input logic [15:0] e_d);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.t = t; r.d = d;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_t = e_t; r.e_d = e_d;
        return r;
    endfunction

    // Ungated payload fields, all derived from one 16-bit tag.
    function automatic logic [63:0] exp_pay(input logic [15:0] d, input logic [1:0] t);
        return {d[2], d[3], d[6:4], d[7], d, ~d, d ^ 16'h5a5a, d[12:8], t};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic [3:0] fl,
                         input logic [1:0] t, input logic [15:0] d);
        in_valid = iv; out_ready = ordy; flush_thread = fl; thread_id_in = t;
        WRegEn_in = d[0]; WMemEn_in = d[1]; alu_src_in = d[2]; mem_to_reg_in = d[3];
        func3_in = d[6:4]; func7_in = d[7]; R1out_in = d; R2out_in = ~d;
        sign_ext_in = d ^ 16'h5a5a; WReg1_in = d[12:8];
    endtask

    initial begin
        drive(0, 0, 4'b0, 2'd0, 16'h0);
        repeat (2) @(posedge CLK);
        #4 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset WRegEn_out", WRegEn_out, 0);
        chk("reset payload", exp_pay(16'h0, 2'd0) & 64'h0, {alu_src_out, mem_to_reg_out, func3_out,
            func7_out, R1out_out, R2out_out, sign_ext_out, WReg1_out, thread_id_out});
        chk("reset bubble_cnt", bubble_cnt, 0);

        tbl.push_back(v(1, 0, 4'h0, 2'd0, 16'h1000, 1, 0, 2'd0, 16'h0));
        for (int k = 1; k < 8; k++)
            tbl.push_back(v(1, 1, 4'h0, 2'(k), 16'h1000 + 16'(k), 1, 1, 2'(k - 1), 16'h1000 + 16'(k - 1)));
        tbl.push_back(v(0, 1, 4'h0, 2'd0, 16'h0, 1, 1, 2'd3, 16'h1007));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd0, 16'h2001, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd0, 16'h2002, 1, 1, 2'd0, 16'h2001));
        tbl.push_back(v(1, 0, 4'h0, 2'd0, 16'h2003, 0, 1, 2'd0, 16'h2001));
        tbl.push_back(v(1, 1, 4'h0, 2'd0, 16'h2003, 0, 1, 2'd0, 16'h2001));
        tbl.push_back(v(1, 1, 4'h0, 2'd0, 16'h2003, 1, 1, 2'd0, 16'h2002));
        tbl.push_back(v(0, 1, 4'h0, 2'd0, 16'h0, 1, 1, 2'd0, 16'h2003));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd1, 16'h3001, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd2, 16'h3003, 1, 1, 2'd1, 16'h3001));
        tbl.push_back(v(0, 0, 4'h2, 2'd0, 16'h0, 0, 0, 2'd0, 16'h0));
        tbl.push_back(v(0, 1, 4'h0, 2'd0, 16'h0, 1, 1, 2'd2, 16'h3003));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h8, 2'd3, 16'h4003, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h8, 2'd0, 16'h4010, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h1, 2'd1, 16'h4011, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(0, 1, 4'h0, 2'd0, 16'h0, 1, 1, 2'd1, 16'h4011));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd0, 16'h5000, 1, 0, 2'd0, 16'h0));
        tbl.push_back(v(1, 0, 4'h0, 2'd1, 16'h5001, 1, 1, 2'd0, 16'h5000));
        tbl.push_back(v(0, 0, 4'h2, 2'd0, 16'h0, 0, 1, 2'd0, 16'h5000));
        tbl.push_back(v(1, 1, 4'h0, 2'd2, 16'h5002, 1, 1, 2'd0, 16'h5000));
        tbl.push_back(v(0, 1, 4'h0, 2'd0, 16'h0, 1, 1, 2'd2, 16'h5002));
        tbl.push_back(v(0, 0, 4'h0, 2'd0, 16'h0, 1, 0, 2'd0, 16'h0));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].t, tbl[i].d);
            #1;
            chk($sformatf("c%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("c%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("c%0d WRegEn_out", i), WRegEn_out, tbl[i].e_ov & tbl[i].e_d[0]);
            chk($sformatf("c%0d WMemEn_out", i), WMemEn_out, tbl[i].e_ov & tbl[i].e_d[1]);
            if (tbl[i].e_ov)
                chk($sformatf("c%0d payload", i), {alu_src_out, mem_to_reg_out, func3_out, func7_out,
                    R1out_out, R2out_out, sign_ext_out, WReg1_out, thread_id_out}, exp_pay(tbl[i].e_d, tbl[i].e_t));
            @(posedge CLK); #1;
        end
        chk("no bubbles in table", bubble_cnt, 0);

        // Fill main+skid, then pull reset between edges.
        drive(1, 0, 4'h0, 2'd1, 16'h6001);
        @(posedge CLK); #1;
        drive(1, 0, 4'h0, 2'd1, 16'h6002);
        @(posedge CLK); #1;
        drive(0, 0, 4'h0, 2'd0, 16'h0);
        #1;
        chk("skid in_ready", in_ready, 0);
        chk("skid out_valid", out_valid, 1);
        chk("skid WRegEn_out", WRegEn_out, 1);
        #1 RST_N = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst WRegEn_out", WRegEn_out, 0);
        chk("async rst in_ready", in_ready, 1);
        chk("async rst R1out", R1out_out, 0);
        #3 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("post rst out_valid", out_valid, 0);
        chk("post rst in_ready", in_ready, 1);
        chk("post rst bubble_cnt", bubble_cnt, 0);

        drive(0, 1, 4'h0, 2'd0, 16'h0);
        repeat (10) @(posedge CLK);
        #1 chk("bubble count 10", bubble_cnt, 10);
        repeat (65529) @(posedge CLK);
        #1 chk("bubble saturate", bubble_cnt, 16'hffff);
        repeat (3) @(posedge CLK);
        #1 chk("bubble no wrap", bubble_cnt, 16'hffff);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
